// File: rtl/approx_eight_bit_seq_divider.sv
// ---------------------------------------------------------------------------
// approx_eight_bit_seq_divider
//
// Sequential unsigned restoring divider, DW_DIVIDEND-bit dividend by
// DW_DIVISOR-bit divisor. It is the inverse of the 8x8 multiplier datapath:
// feeding a product back in with one operand recovers the other operand.
// The divider produces one quotient bit per clock. Both the operand side and
// the result side use a valid/ready handshake.
//
// Optional feature macro: APPROX_DIV_ERR_EN
//   defined   -> adds the div_err output, which flags a zero divisor.
//   undefined -> there is no div_err port. A zero divisor still returns
//                all-ones / dividend[7:0].
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (IDLE only)
//   dividend   in   numerator
//   divisor    in   denominator
//   out_valid  out  result valid (DONE only)
//   out_ready  in   downstream accepts result
//   quotient   out  floor(dividend/divisor), 16'hFFFF on divide-by-zero
//   remainder  out  dividend mod divisor, dividend[7:0] on divide-by-zero
//   div_err    out  divide-by-zero flag (APPROX_DIV_ERR_EN only)
//
// Latency: if in_valid is presented after edge N and accepted at edge N+1,
// out_valid rises after edge N+17. For a zero divisor it rises after N+1.
// CNT_W must satisfy 2**CNT_W > DW_DIVIDEND.
// ---------------------------------------------------------------------------
module approx_eight_bit_seq_divider #(
    parameter int DW_DIVIDEND = 16,
    parameter int DW_DIVISOR  = 8,
    parameter int CNT_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW_DIVIDEND-1:0] dividend,
    input  logic [DW_DIVISOR-1:0]  divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW_DIVIDEND-1:0] quotient,
    output logic [DW_DIVISOR-1:0]  remainder
`ifdef APPROX_DIV_ERR_EN
    ,
    output logic                   div_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Working registers. R is one bit wider than the divisor, so the
    // shifted partial remainder can be compared against any divisor up to
    // 2**DW_DIVISOR-1 without overflow.
    logic [DW_DIVIDEND-1:0] q_reg;
    logic [DW_DIVISOR:0]    r_reg;
    logic [DW_DIVISOR-1:0]  d_reg;
    logic [CNT_W-1:0]       count;

    // One restoring step.
    logic [DW_DIVISOR+1:0]  r_wide;
    logic                   r_ge;
    logic [DW_DIVISOR:0]    r_next;
    logic [DW_DIVIDEND-1:0] q_next;
    logic                   last_step;
    logic                   accept;
    logic                   zero_div;

    always_comb begin
        r_wide    = {r_reg, q_reg[DW_DIVIDEND-1]};
        r_ge      = (r_wide >= {2'b00, d_reg});
        r_next    = (DW_DIVISOR+1)'(r_ge ? (r_wide - {2'b00, d_reg}) : r_wide);
        q_next    = {q_reg[DW_DIVIDEND-2:0], r_ge};
        last_step = (count == CNT_W'(DW_DIVIDEND - 1));
        accept    = (state == IDLE) && in_valid;
        zero_div  = (divisor == '0);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = zero_div ? DONE : CALC;
            end
            CALC: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                q_reg <= dividend;
                r_reg <= '0;
                d_reg <= divisor;
                count <= '0;
                // A zero divisor skips CALC, so its result is loaded here.
                if (zero_div) begin
                    quotient  <= '1;
                    remainder <= dividend[DW_DIVISOR-1:0];
                end
            end else if (state == CALC) begin
                q_reg <= q_next;
                r_reg <= r_next;
                count <= count + 1'b1;
                // Load the outputs only when the final bit is produced. They
                // then hold through DONE and after the handshake.
                if (last_step) begin
                    quotient  <= q_next;
                    remainder <= DW_DIVISOR'(r_next);
                end
            end
        end
    end

`ifdef APPROX_DIV_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            div_err <= 1'b0;
        else if (accept)
            div_err <= zero_div;
        else if ((state == DONE) && out_ready)
            div_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_approx_eight_bit_seq_divider.sv
module tb_approx_eight_bit_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] quotient;
    logic [7:0]  remainder;
`ifdef APPROX_DIV_ERR_EN
    logic        div_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    approx_eight_bit_seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef APPROX_DIV_ERR_EN
        ,
        .div_err   (div_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Present the operands after an edge. Count edges, starting with the
    // accepting edge, until out_valid is seen. Then check the result. The
    // caller controls out_ready.
    task automatic start_and_wait(input string tag, input logic [15:0] a, input logic [7:0] b,
                                  input int exp_lat, input logic [15:0] exp_q,
                                  input logic [7:0] exp_r);
        int n;
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            in_valid = 1'b0;
            // Operand changes outside IDLE must be ignored.
            dividend = 16'hDEAD;
            divisor  = 8'h03;
        end while (!out_valid && n < 40);
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".quotient"}, quotient, exp_q);
        chk({tag, ".remainder"}, remainder, exp_r);
        chk({tag, ".in_ready_done"}, in_ready, 0);
    endtask

    // Run one division with out_ready=1, then check the return to IDLE.
    task automatic div_case(input string tag, input logic [15:0] a, input logic [7:0] b,
                            input int exp_lat, input logic [15:0] exp_q, input logic [7:0] exp_r);
        out_ready = 1'b1;
        start_and_wait(tag, a, b, exp_lat, exp_q, exp_r);
        @(negedge clk);
        chk({tag, ".out_valid_drop"}, out_valid, 0);
        chk({tag, ".in_ready_back"}, in_ready, 1);
        chk({tag, ".quotient_held"}, quotient, exp_q);
        chk({tag, ".remainder_held"}, remainder, exp_r);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.quotient", quotient, 0);
        chk("rst.remainder", remainder, 0);
`ifdef APPROX_DIV_ERR_EN
        chk("rst.div_err", div_err, 0);
`endif
        rst_n = 1'b1;

        // Main cases
        div_case("d1000_7", 16'd1000, 8'd7, 17, 16'd142, 8'd6);
        div_case("d65535_255", 16'd65535, 8'd255, 17, 16'd257, 8'd0);
        div_case("d5_10", 16'd5, 8'd10, 17, 16'd0, 8'd5);
        div_case("d65535_1", 16'd65535, 8'd1, 17, 16'd65535, 8'd0);
        div_case("d12345_123", 16'd12345, 8'd123, 17, 16'd100, 8'd45);
        div_case("d40000_200", 16'd40000, 8'd200, 17, 16'd200, 8'd0);

        // Divide by zero
        out_ready = 1'b0;
        start_and_wait("dz", 16'h1234, 8'd0, 1, 16'hFFFF, 8'h34);
`ifdef APPROX_DIV_ERR_EN
        chk("dz.div_err", div_err, 1);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        chk("dz.out_valid_drop", out_valid, 0);
        chk("dz.in_ready_back", in_ready, 1);
`ifdef APPROX_DIV_ERR_EN
        chk("dz.div_err_clr", div_err, 0);
`endif

        // Hold in DONE with out_ready low. An in_valid pulse here is ignored.
        out_ready = 1'b0;
        start_and_wait("hold", 16'd300, 8'd16, 17, 16'd18, 8'd12);
        for (int i = 0; i < 5; i++) begin
            dividend = 16'd99;
            divisor  = 8'd3;
            in_valid = (i == 2);
            @(posedge clk);
            @(negedge clk);
            chk("hold.out_valid", out_valid, 1);
            chk("hold.in_ready", in_ready, 0);
            chk("hold.quotient", quotient, 18);
            chk("hold.remainder", remainder, 12);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold.out_valid_drop", out_valid, 0);
        chk("hold.in_ready_back", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("hold.still_idle", in_ready, 1);
        chk("hold.no_accept", quotient, 18);

        // Reset in CALC when count == 8
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);                // accept, count=0
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort.calc_in_ready", in_ready, 0);
        repeat (8) @(posedge clk);     // count reaches 8
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort.in_ready", in_ready, 1);
        chk("abort.out_valid", out_valid, 0);
        chk("abort.quotient", quotient, 0);
        chk("abort.remainder", remainder, 0);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort.no_result", out_valid, 0);
        end
        div_case("abort.redo", 16'd1000, 8'd7, 17, 16'd142, 8'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
